// File: rtl/apb_pkg.sv
// +----------------------------------------------------------------------+
// | apb_pkg: shared APB types, default widths and strobe-width helper.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int APB_ADDWIDTH  = 8;
  localparam int APB_DATAWIDTH = 32;

  function automatic int strb_width(input int dw);
    return dw / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/apb_master_bridge.sv
// +----------------------------------------------------------------------+
// | apb_master_bridge: valid/ready command to single APB transfer bridge |
// | with PREADY wait timeout. Revision: 1.0                              |
// +----------------------------------------------------------------------+
`default_nettype none

module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDWIDTH  = APB_ADDWIDTH,
  parameter int DATAWIDTH = APB_DATAWIDTH,
  parameter int TIMEOUT   = 16
) (
  input  logic                                PCLK,
  input  logic                                PRESET,
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic                                cmd_write,
  input  logic [ADDWIDTH-1:0]                 cmd_addr,
  input  logic [DATAWIDTH-1:0]                cmd_wdata,
  input  logic [strb_width(DATAWIDTH)-1:0]    cmd_strb,
  output logic                                rsp_valid,
  output logic [DATAWIDTH-1:0]                rsp_rdata,
  output logic                                rsp_err,
  output logic                                PSEL,
  output logic                                PENABLE,
  output logic                                PWRITE,
  output logic [ADDWIDTH-1:0]                 PADDR,
  output logic [DATAWIDTH-1:0]                PWDATA,
  output logic [strb_width(DATAWIDTH)-1:0]    PSTRB,
  input  logic                                PREADY,
  input  logic [DATAWIDTH-1:0]                PRDATA
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] c_last = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] c_max  = '1;

  apb_state_e          r_state;
  logic [CW-1:0]       r_wait_cnt;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      PSTRB      <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            PWRITE    <= cmd_write;
            PADDR     <= cmd_addr;
            PWDATA    <= cmd_write ? cmd_wdata : '0;
            PSTRB     <= cmd_write ? cmd_strb : '0;
            PSEL      <= 1'b1;
            PENABLE   <= 1'b0;
            cmd_ready <= 1'b0;
            r_state   <= SETUP;
          end
        end
        SETUP: begin
          PENABLE    <= 1'b1;
          r_wait_cnt <= '0;
          r_state    <= ACCESS;
        end
        ACCESS: begin
          // PREADY is tested first so it wins over a coincident timeout.
          if (PREADY) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= PWRITE ? '0 : PRDATA;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            cmd_ready <= 1'b1;
            r_state   <= IDLE;
          end else if ((TIMEOUT != 0) && (r_wait_cnt == c_last)) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            cmd_ready <= 1'b1;
            r_state   <= IDLE;
          end else if (r_wait_cnt != c_max) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        default: begin
          PSEL      <= 1'b0;
          PENABLE   <= 1'b0;
          cmd_ready <= 1'b1;
          r_state   <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
